// File: rtl/cpc_ram_pkg.sv
// Shared definitions for the CPC RAM banker: config encodings, page numbers
// and the page-to-block mapping used by the decode.
package cpc_ram_pkg;

  localparam logic [2:0] CFG_STD    = 3'd0;
  localparam logic [2:0] CFG_P3     = 3'd1;
  localparam logic [2:0] CFG_ALL    = 3'd2;
  localparam logic [2:0] CFG_P3V    = 3'd3;
  localparam logic [2:0] CFG_P1BASE = 3'd4;

  localparam logic [1:0] PAGE0 = 2'd0;
  localparam logic [1:0] PAGE1 = 2'd1;
  localparam logic [1:0] PAGE2 = 2'd2;
  localparam logic [1:0] PAGE3 = 2'd3;

  typedef enum logic {StIdle, StArmed} latch_state_e;

  // Returns {ext, blk}; blk is meaningless when ext is 0.
  function automatic logic [2:0] map_page(input logic [2:0] cfg, input logic [1:0] p);
    logic       ext;
    logic [1:0] blk;
    ext = 1'b0;
    blk = p;
    case (cfg)
      CFG_STD: ext = 1'b0;
      CFG_P3, CFG_P3V: begin
        ext = (p == PAGE3);
        blk = PAGE3;
      end
      CFG_ALL: begin
        ext = 1'b1;
        blk = p;
      end
      default: begin
        ext = (p == PAGE1);
        blk = cfg[1:0] - CFG_P1BASE[1:0];
      end
    endcase
    return {ext, blk};
  endfunction

endpackage

// File: rtl/cpc_ram_cfg_latch.sv
// Captures RAM configuration writes into a shadow register while the strobe is
// active and commits them to the active config once the strobe ends.
module cpc_ram_cfg_latch
  import cpc_ram_pkg::*;
#(
  parameter int unsigned BANK_BITS = 3,
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned MIRROR    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          a,
  input  logic [7:0]           d,
  input  logic                 ioreq_b,
  input  logic                 wr_b,
  output logic [2:0]           cfg,
  output logic [BANK_BITS-1:0] bank
);

  localparam logic [BANK_BITS:0] NumBanksW = (BANK_BITS + 1)'(NUM_BANKS);

  latch_state_e         state_q;
  logic [2:0]           shadow_cfg_q, cfg_q, commit_cfg;
  logic [BANK_BITS-1:0] shadow_bank_q, bank_q, commit_bank, wbank;
  logic [BANK_BITS:0]   mirrored;
  logic                 wsel, unused_a;

  assign wsel     = ~ioreq_b & ~wr_b & ~a[15] & d[7] & d[6];
  assign unused_a = ^a;

  // Bank bits above the three from the data bus come from the inverted upper address.
  if (BANK_BITS > 3) begin : g_ext_bank
    assign wbank = {~a[BANK_BITS+4:8], d[5:3]};
  end else begin : g_std_bank
    assign wbank = d[5:3];
  end

  always_comb begin
    commit_cfg  = shadow_cfg_q;
    commit_bank = shadow_bank_q;
    mirrored    = {1'b0, shadow_bank_q} % NumBanksW;
    if (MIRROR != 0) begin
      commit_bank = mirrored[BANK_BITS-1:0];
    end else if ({1'b0, shadow_bank_q} >= NumBanksW) begin
      commit_cfg = CFG_STD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      shadow_cfg_q  <= '0;
      shadow_bank_q <= '0;
      cfg_q         <= '0;
      bank_q        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (wsel) begin
            shadow_cfg_q  <= d[2:0];
            shadow_bank_q <= wbank;
            state_q       <= StArmed;
          end
        end
        StArmed: begin
          if (wsel) begin
            shadow_cfg_q  <= d[2:0];
            shadow_bank_q <= wbank;
          end else begin
            cfg_q   <= commit_cfg;
            bank_q  <= commit_bank;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg  = cfg_q;
  assign bank = bank_q;

endmodule

// File: rtl/cpc_ram_banker.sv
// CPC 6128-style RAM expansion: config capture plus combinational decode of the
// live Z80 address into RAMDIS, SRAM chip select and SRAM high address bits.
module cpc_ram_banker
  import cpc_ram_pkg::*;
#(
  parameter int unsigned BANK_BITS = 3,
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned MIRROR    = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [15:0]            A,
  input  logic [7:0]             D,
  input  logic                   IOREQ_B,
  input  logic                   WR_B,
  input  logic                   MREQ_B,
  input  logic                   RFSH_B,
  output logic                   RAMDIS,
  output logic                   RAMCS_B,
  output logic [BANK_BITS+1:0]   RAM_ADR_HI,
  output logic [2:0]             CFG_Q,
  output logic [BANK_BITS-1:0]   BANK_Q
);

  logic [2:0]           cfg;
  logic [BANK_BITS-1:0] bank;
  logic [2:0]           pm;
  logic                 ext;
  logic [1:0]           blk;

  cpc_ram_cfg_latch #(
    .BANK_BITS (BANK_BITS),
    .NUM_BANKS (NUM_BANKS),
    .MIRROR    (MIRROR)
  ) u_cfg_latch (
    .clk     (CLK),
    .reset   (RESET),
    .a       (A),
    .d       (D),
    .ioreq_b (IOREQ_B),
    .wr_b    (WR_B),
    .cfg     (cfg),
    .bank    (bank)
  );

  assign pm  = map_page(cfg, A[15:14]);
  assign ext = pm[2];
  assign blk = pm[1:0];

  // Refresh cycles keep RAMDIS but never select the SRAM.
  assign RAMDIS     = ext;
  assign RAMCS_B    = ~(ext & ~MREQ_B & RFSH_B);
  assign RAM_ADR_HI = ext ? {bank, blk} : '0;
  assign CFG_Q      = cfg;
  assign BANK_Q     = bank;

endmodule

// File: tb/tb_cpc_ram_banker.sv
// Directed bench for cpc_ram_banker: a vector table on the default build plus
// hand sequences for latency, wide banks, range check, mirroring and reset.
module tb_cpc_ram_banker;

  logic        clk, reset;
  logic [15:0] a;
  logic [7:0]  d;
  logic        ioreq_b, wr_b, mreq_b, rfsh_b;

  logic       dis0, cs0;
  logic [4:0] hi0;
  logic [2:0] cfg0;
  logic [2:0] bank0;

  logic       dis6, cs6;
  logic [7:0] hi6;
  logic [2:0] cfg6;
  logic [5:0] bank6;

  logic       dis4, cs4;
  logic [4:0] hi4;
  logic [2:0] cfg4;
  logic [2:0] bank4;

  logic       dism, csm;
  logic [4:0] him;
  logic [2:0] cfgm;
  logic [2:0] bankm;

  int checks = 0;
  int errs   = 0;

  cpc_ram_banker dut (
    .CLK(clk), .RESET(reset), .A(a), .D(d), .IOREQ_B(ioreq_b), .WR_B(wr_b),
    .MREQ_B(mreq_b), .RFSH_B(rfsh_b), .RAMDIS(dis0), .RAMCS_B(cs0),
    .RAM_ADR_HI(hi0), .CFG_Q(cfg0), .BANK_Q(bank0)
  );

  cpc_ram_banker #(.BANK_BITS(6), .NUM_BANKS(64), .MIRROR(0)) dut6 (
    .CLK(clk), .RESET(reset), .A(a), .D(d), .IOREQ_B(ioreq_b), .WR_B(wr_b),
    .MREQ_B(mreq_b), .RFSH_B(rfsh_b), .RAMDIS(dis6), .RAMCS_B(cs6),
    .RAM_ADR_HI(hi6), .CFG_Q(cfg6), .BANK_Q(bank6)
  );

  cpc_ram_banker #(.BANK_BITS(3), .NUM_BANKS(4), .MIRROR(0)) dut4 (
    .CLK(clk), .RESET(reset), .A(a), .D(d), .IOREQ_B(ioreq_b), .WR_B(wr_b),
    .MREQ_B(mreq_b), .RFSH_B(rfsh_b), .RAMDIS(dis4), .RAMCS_B(cs4),
    .RAM_ADR_HI(hi4), .CFG_Q(cfg4), .BANK_Q(bank4)
  );

  cpc_ram_banker #(.BANK_BITS(3), .NUM_BANKS(4), .MIRROR(1)) dut4m (
    .CLK(clk), .RESET(reset), .A(a), .D(d), .IOREQ_B(ioreq_b), .WR_B(wr_b),
    .MREQ_B(mreq_b), .RFSH_B(rfsh_b), .RAMDIS(dism), .RAMCS_B(csm),
    .RAM_ADR_HI(him), .CFG_Q(cfgm), .BANK_Q(bankm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]  d;
    logic [15:0] a;
    logic        mreq_b;
    logic        rfsh_b;
    logic        dis;
    logic        cs_b;
    logic [4:0]  hi;
    logic [2:0]  cfg;
    logic [2:0]  bank;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    ioreq_b = 1'b1;
    wr_b    = 1'b1;
    mreq_b  = 1'b1;
    rfsh_b  = 1'b1;
  endtask

  // Hold the I/O write strobe for n edges, release it, then clock the commit edge.
  task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input int n);
    a       = addr;
    d       = data;
    ioreq_b = 1'b0;
    wr_b    = 1'b0;
    mreq_b  = 1'b1;
    for (int k = 0; k < n; k++) tick();
    ioreq_b = 1'b1;
    wr_b    = 1'b1;
    tick();
  endtask

  task automatic mem(input logic [15:0] addr, input logic mq, input logic rf);
    a      = addr;
    mreq_b = mq;
    rfsh_b = rf;
    #1;
  endtask

  initial begin
    vecs[0]  = '{8'hC1, 16'hC123, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00011, 3'd1, 3'd0};
    vecs[1]  = '{8'hC1, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00000, 3'd1, 3'd0};
    vecs[2]  = '{8'hD2, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 5'b01000, 3'd2, 3'd2};
    vecs[3]  = '{8'hD2, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 5'b01010, 3'd2, 3'd2};
    vecs[4]  = '{8'hCB, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00000, 3'd3, 3'd1};
    vecs[5]  = '{8'hCB, 16'hF000, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00111, 3'd3, 3'd1};
    vecs[6]  = '{8'hFD, 16'h5555, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11101, 3'd5, 3'd7};
    vecs[7]  = '{8'hFD, 16'hC000, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00000, 3'd5, 3'd7};
    vecs[8]  = '{8'hE7, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b1, 5'b10011, 3'd7, 3'd4};
    vecs[9]  = '{8'hC0, 16'hC000, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00000, 3'd0, 3'd0};
    vecs[10] = '{8'hC4, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 3'd4, 3'd0};

    reset = 1'b1;
    a     = 16'h0000;
    d     = 8'h00;
    idle_bus();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    mem(16'hC000, 1'b0, 1'b1);
    chk("rst ramdis", dis0, 1'b0);
    chk("rst ramcs_b", cs0, 1'b1);
    chk("rst adr_hi", hi0, 5'd0);
    chk("rst cfg", cfg0, 3'd0);
    chk("rst bank", bank0, 3'd0);
    chk("rst bank6", bank6, 6'd0);
    idle_bus();

    // Three-cycle strobe: old config stays visible until after the commit edge
    a       = 16'h7F00;
    d       = 8'hC1;
    ioreq_b = 1'b0;
    wr_b    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("strobe%0d cfg", k), cfg0, 3'd0);
    end
    ioreq_b = 1'b1;
    wr_b    = 1'b1;
    #1;
    chk("pre-commit cfg", cfg0, 3'd0);
    tick();
    mem(16'hC123, 1'b0, 1'b1);
    chk("lat ramdis", dis0, 1'b1);
    chk("lat ramcs_b", cs0, 1'b0);
    chk("lat adr_hi", hi0, 5'b00011);
    idle_bus();

    // Table-driven decode on the default build
    for (int i = 0; i < 11; i++) begin
      io_write(16'h7F00, vecs[i].d, 1);
      mem(vecs[i].a, vecs[i].mreq_b, vecs[i].rfsh_b);
      chk($sformatf("row%0d ramdis", i), dis0, vecs[i].dis);
      chk($sformatf("row%0d ramcs_b", i), cs0, vecs[i].cs_b);
      chk($sformatf("row%0d adr_hi", i), hi0, vecs[i].hi);
      chk($sformatf("row%0d cfg", i), cfg0, vecs[i].cfg);
      chk($sformatf("row%0d bank", i), bank0, vecs[i].bank);
      idle_bus();
    end

    // Six-bit bank: upper bits from inverted A[10:8]
    io_write(16'h7A00, 8'hFE, 2);
    mem(16'h4000, 1'b0, 1'b1);
    chk("wide bank", bank6, 6'd47);
    chk("wide adr_hi", hi6, {6'd47, 2'b10});
    chk("wide ramcs_b", cs6, 1'b0);
    mem(16'h8000, 1'b0, 1'b1);
    chk("wide p2 ramdis", dis6, 1'b0);
    chk("wide p2 adr_hi", hi6, 8'd0);
    idle_bus();

    // Out-of-range bank: disabled without mirror, wrapped with mirror
    io_write(16'h7F00, 8'hE9, 1);
    mem(16'hC000, 1'b0, 1'b1);
    chk("oor cfg", cfg4, 3'd0);
    chk("oor bank", bank4, 3'd5);
    chk("oor ramcs_b", cs4, 1'b1);
    chk("oor ramdis", dis4, 1'b0);
    chk("mir cfg", cfgm, 3'd1);
    chk("mir bank", bankm, 3'd1);
    chk("mir adr_hi", him, 5'b00111);
    chk("mir ramcs_b", csm, 1'b0);
    chk("8bank bank", bank0, 3'd5);
    idle_bus();

    // Reset while armed discards the pending write
    io_write(16'h7F00, 8'hC1, 1);
    chk("pre-arm cfg", cfg0, 3'd1);
    a       = 16'h7F00;
    d       = 8'hC2;
    ioreq_b = 1'b0;
    wr_b    = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    ioreq_b = 1'b1;
    wr_b    = 1'b1;
    tick();
    tick();
    chk("armed-reset cfg", cfg0, 3'd0);
    chk("armed-reset bank", bank0, 3'd0);

    // Writes that must be ignored
    io_write(16'h7F00, 8'hC1, 1);
    io_write(16'h7F00, 8'h82, 2);
    chk("d76 ignore cfg", cfg0, 3'd1);
    io_write(16'hFF00, 8'hC2, 2);
    chk("a15 ignore cfg", cfg0, 3'd1);
    a      = 16'h7F00;
    d      = 8'hC2;
    wr_b   = 1'b0;
    mreq_b = 1'b0;
    tick();
    idle_bus();
    tick();
    chk("memwr ignore cfg", cfg0, 3'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
